fft_dif_pair_feeder: RTL and testbench



---
 rtl/fft_dif_pair_feeder_if.sv | 35 +++
 rtl/fft_dif_pair_feeder.sv | 113 +++++++++++
 tb/tb_fft_dif_pair_feeder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_dif_pair_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_dif_pair_feeder_if
// Brief    : Sample-in / butterfly-pair-out bundle for the DIF pair feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_dif_pair_feeder_if #(
  parameter int N      = 8,
  parameter int I_DATA = 32
);
  localparam int TW_W = $clog2(N) - 1;

  // Complex samples are packed {r, i}, r in the upper I_DATA bits.
  logic                  in_valid;
  logic [2*I_DATA-1:0]   in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_valid;
  logic [2*I_DATA-1:0]   A;
  logic [2*I_DATA-1:0]   B;
  logic [TW_W-1:0]       tw_idx;
  logic                  out_last;
  logic                  frame_err;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, A, B, tw_idx, out_last, frame_err
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, A, B, tw_idx, out_last, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/fft_dif_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft_dif_pair_feeder
// Brief    : Buffers the first half of each frame and issues (x[n], x[n+N/2])
//            pairs with twiddle index n to a radix-2 DIF butterfly.
// Revision : 1.0 - initial release
// ============================================================================
module fft_dif_pair_feeder #(
  parameter int N      = 8,
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  fft_dif_pair_feeder_if.slave   bus
);
  localparam int CW   = $clog2(N);
  localparam int HALF = N / 2;
  localparam int DW   = 2 * I_DATA;

  localparam logic [0:0]    S_FILL  = 1'b0;
  localparam logic [0:0]    S_PAIR  = 1'b1;
  localparam logic [CW-1:0] C_LAST  = CW'(N - 1);
  localparam logic [CW-2:0] C_NLAST = CW'(HALF - 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  sbuf_q [HALF];
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [CW-2:0]  tw_q, tw_d;
  logic           out_last_q, out_last_d;
  logic           frame_err_q, frame_err_d;
  logic           w_buf_we;
  logic           w_accept;
  logic [0:0]     w_state;
  logic [CW-2:0]  w_n;

  // The FILL/PAIR state is simply the counter MSB.
  assign w_state  = cnt_q[CW-1];
  assign w_n      = cnt_q[CW-2:0];
  assign w_accept = bus.in_valid & ~reset;

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    tw_d        = tw_q;
    out_last_d  = out_last_q;
    frame_err_d = frame_err_q;
    w_buf_we    = 1'b0;
    if (w_accept) begin
      if (bus.in_last && (cnt_q != C_LAST)) begin
        // Early end-of-frame: drop this sample and restart at index 0.
        frame_err_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.in_last && (cnt_q == C_LAST)) begin
          frame_err_d = 1'b1;
        end
        if (w_state == S_FILL) begin
          w_buf_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          a_d         = sbuf_q[w_n];
          b_d         = bus.in_data;
          tw_d        = w_n;
          out_last_d  = (w_n == C_NLAST);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tw_q        <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tw_q        <= tw_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Buffer needs no reset: every entry is rewritten during FILL before use.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      sbuf_q[w_n] <= bus.in_data;
    end
  end

  assign bus.in_ready  = ~reset;
  assign bus.out_valid = out_valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.tw_idx    = tw_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_dif_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_dif_pair_feeder
// Brief    : Scoreboard bench for fft_dif_pair_feeder with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_dif_pair_feeder;
  localparam int N  = 8;
  localparam int DW = 64;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  fft_dif_pair_feeder_if #(.N(N), .I_DATA(32)) io ();

  fft_dif_pair_feeder #(.N(N), .I_EXP(8), .I_MNT(23)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (io.slave)
  );

  typedef struct {
    int            c;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    tw;
    logic          last;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: flags overdue expectations, then matches each strobe to the queue head.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_pair: no strobe at cycle %0d for A=%h B=%h tw=%0d",
               q[0].c, q[0].a, q[0].b, q[0].tw);
      void'(q.pop_front());
    end
    if (io.out_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pair: cycle %0d A=%h B=%h tw=%0d, none expected",
                 cyc, io.A, io.B, io.tw_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.c != cyc || io.A !== e.a || io.B !== e.b || io.tw_idx !== e.tw
            || io.out_last !== e.last) begin
          bad++;
          $display("FAIL pair: got cyc=%0d A=%h B=%h tw=%0d last=%b expected cyc=%0d A=%h B=%h tw=%0d last=%b",
                   cyc, io.A, io.B, io.tw_idx, io.out_last, e.c, e.a, e.b, e.tw, e.last);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit last, input bit exp_en,
                      input logic [DW-1:0] ea, input int tw);
    exp_t e;
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.in_last  = last;
    if (exp_en) begin
      e.c    = cyc + 1;
      e.a    = ea;
      e.b    = d;
      e.tw   = 2'(tw);
      e.last = (tw == 3);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sample k of the second half pairs with f[k-4], twiddle k-4.
  task automatic send_frame(input logic [DW-1:0] f [8], input logic [7:0] gap_mask,
                            input int gap_len, input bit give_last);
    for (int k = 0; k < 8; k++) begin
      send(f[k], give_last && (k == 7), k >= 4, f[k & 3], k & 3);
      if (gap_mask[k]) idle(gap_len);
    end
  endtask

  logic [DW-1:0] f1 [8];
  logic [DW-1:0] f2 [8];
  logic [DW-1:0] fs [8];

  initial begin
    f1[0] = {32'h3f800000, 32'h0}; f1[1] = {32'h40000000, 32'h0};
    f1[2] = {32'h40400000, 32'h0}; f1[3] = {32'h40800000, 32'h0};
    f1[4] = {32'h40a00000, 32'h0}; f1[5] = {32'h40c00000, 32'h0};
    f1[6] = {32'h40e00000, 32'h0}; f1[7] = {32'h41000000, 32'h0};
    f2[0] = {32'h41100000, 32'h0}; f2[1] = {32'h41200000, 32'h0};
    f2[2] = {32'h41300000, 32'h0}; f2[3] = {32'h41400000, 32'h0};
    f2[4] = {32'h41500000, 32'h0}; f2[5] = {32'h41600000, 32'h0};
    f2[6] = {32'h41700000, 32'h0}; f2[7] = {32'h41800000, 32'h0};
    fs[0] = {32'hbf800000, 32'h7fc00000}; fs[1] = {32'h7fc00000, 32'hff800000};
    fs[2] = {32'hff800000, 32'hbf800000}; fs[3] = {32'h80000000, 32'h7f800000};
    fs[4] = {32'h7f800000, 32'hbf800000}; fs[5] = {32'hbf800000, 32'hff800000};
    fs[6] = {32'h7fc00000, 32'h80000000}; fs[7] = {32'hff800000, 32'h7fc00000};

    cyc   = 0;
    total = 0;
    bad   = 0;
    io.in_valid = 1'b0;
    io.in_data  = '0;
    io.in_last  = 1'b0;
    reset = 1'b1;
    idle(2);
    check("rst_out_valid", 64'(io.out_valid), 64'd0);
    check("rst_A",         io.A,              64'd0);
    check("rst_B",         io.B,              64'd0);
    check("rst_tw_idx",    64'(io.tw_idx),    64'd0);
    check("rst_out_last",  64'(io.out_last),  64'd0);
    check("rst_frame_err", 64'(io.frame_err), 64'd0);
    check("rst_in_ready",  64'(io.in_ready),  64'd0);
    reset = 1'b0;
    #1;
    check("in_ready_run",  64'(io.in_ready),  64'd1);

    // Single clean frame, then two back-to-back frames.
    send_frame(f1, 8'h00, 0, 1'b1);
    idle(2);
    check("frame_err_clean", 64'(io.frame_err), 64'd0);
    send_frame(f1, 8'h00, 0, 1'b1);
    send_frame(f2, 8'h00, 0, 1'b1);
    idle(2);

    // Input gaps after samples 2 and 6.
    send_frame(f1, 8'h22, 3, 1'b1);
    idle(2);
    check("frame_err_gaps", 64'(io.frame_err), 64'd0);

    // Early in_last on sample 3: dropped, sticky error, resync.
    send(f2[0], 1'b0, 1'b0, '0, 0);
    send(f2[1], 1'b0, 1'b0, '0, 0);
    send(f2[2], 1'b1, 1'b0, '0, 0);
    check("frame_err_early_last", 64'(io.frame_err), 64'd1);
    send_frame(f1, 8'h00, 0, 1'b1);
    idle(2);
    check("frame_err_sticky", 64'(io.frame_err), 64'd1);

    // Reset after sample 6 of a frame.
    for (int k = 0; k < 6; k++) send(f2[k], 1'b0, k >= 4, f2[k & 3], k & 3);
    reset = 1'b1;
    idle(1);
    check("mid_rst_in_ready",  64'(io.in_ready),  64'd0);
    check("mid_rst_out_valid", 64'(io.out_valid), 64'd0);
    check("mid_rst_A",         io.A,              64'd0);
    check("mid_rst_B",         io.B,              64'd0);
    check("mid_rst_tw_idx",    64'(io.tw_idx),    64'd0);
    check("mid_rst_out_last",  64'(io.out_last),  64'd0);
    check("mid_rst_frame_err", 64'(io.frame_err), 64'd0);
    reset = 1'b0;
    send_frame(f1, 8'h00, 0, 1'b1);
    idle(2);

    // Sign/NaN/Inf patterns pass through bit-exact.
    send_frame(fs, 8'h00, 0, 1'b1);
    idle(2);
    check("frame_err_special", 64'(io.frame_err), 64'd0);

    // Missing in_last at the final sample: pairs still emitted, error set.
    send_frame(f2, 8'h00, 0, 1'b0);
    check("frame_err_no_last", 64'(io.frame_err), 64'd1);
    send_frame(f1, 8'h00, 0, 1'b1);
    idle(3);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
